// File: rtl/pix_expand_pkg.sv
// Shared definitions for the pixel expander: pixel-mode encoding, widths and
// per-mode phrase geometry.
package pix_expand_pkg;

  localparam int PHRASE_W = 64;
  localparam int PIX_W    = 32;

  typedef enum logic [1:0] {
    MODE_8  = 2'd0,
    MODE_16 = 2'd1,
    MODE_24 = 2'd2
  } mode_e;

  typedef logic [2:0] idx_t;

  // twentyfour dominates sixteen, matching the saturator's flag decode
  function automatic mode_e decode_mode(input logic sixteen, input logic twentyfour);
    if (twentyfour)   return MODE_24;
    else if (sixteen) return MODE_16;
    else              return MODE_8;
  endfunction

  function automatic logic [3:0] pix_per_phrase(input mode_e m);
    case (m)
      MODE_16: return 4'd4;
      MODE_24: return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  // Pixels per phrase are powers of two, so the start mask doubles as the
  // index of the final pixel in the phrase.
  function automatic idx_t start_mask(input mode_e m);
    case (m)
      MODE_16: return 3'd3;
      MODE_24: return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/pix_expand_if.sv
// Phrase-in / pixel-out handshake bundle between phrase fetch, the expander
// and the ALU input.
interface pix_expand_if;
  import pix_expand_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [PHRASE_W-1:0] in_data;
  logic                in_sixteen;
  logic                in_twentyfour;
  logic [2:0]          in_start;
  logic                in_sign_ext;
  logic                out_valid;
  logic                out_ready;
  logic [PIX_W-1:0]    out_data;
  logic                out_last;

  modport slave (
    input  in_valid, in_data, in_sixteen, in_twentyfour, in_start, in_sign_ext, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_sixteen, in_twentyfour, in_start, in_sign_ext, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/pix_extend.sv
// Combinational pixel selector: picks one pixel out of a phrase by index and
// mode and widens it to 32 bits with zero or sign extension.
module pix_extend
  import pix_expand_pkg::*;
(
  input  logic [PHRASE_W-1:0] phrase_i,
  input  idx_t                index_i,
  input  mode_e               mode_i,
  input  logic                sign_ext_i,
  output logic [PIX_W-1:0]    pix_o
);

  logic [7:0]  raw8;
  logic [15:0] raw16;
  logic [23:0] raw24;

  // 24-bit pixels live in 32-bit slots; the top byte of each slot is dropped
  assign raw8  = phrase_i[{index_i, 3'b000} +: 8];
  assign raw16 = phrase_i[{index_i[1:0], 4'b0000} +: 16];
  assign raw24 = phrase_i[{index_i[0], 5'b00000} +: 24];

  always_comb begin
    pix_o = '0;
    case (mode_i)
      MODE_16: pix_o = sign_ext_i ? {{16{raw16[15]}}, raw16} : {16'h0000, raw16};
      MODE_24: pix_o = sign_ext_i ? {{8{raw24[23]}}, raw24}  : {8'h00, raw24};
      default: pix_o = sign_ext_i ? {{24{raw8[7]}}, raw8}    : {24'h000000, raw8};
    endcase
  end

endmodule

// File: rtl/pix_expand.sv
// Phrase-to-pixel expander: holds one 64-bit phrase and streams its widened
// pixels to the ALU, one per clock, with back-to-back phrase hand-over.
module pix_expand
  import pix_expand_pkg::*;
(
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         flush,
  pix_expand_if.slave  bus
);

  typedef enum logic {ST_EMPTY, ST_HOLD} state_e;

  state_e              state_q,  state_d;
  logic [PHRASE_W-1:0] phrase_q, phrase_d;
  mode_e               mode_q,   mode_d;
  logic                sign_q,   sign_d;
  idx_t                index_q,  index_d;
  logic [PIX_W-1:0]    data_q,   data_d;
  logic                last_q,   last_d;

  mode_e               in_mode;
  idx_t                start_m;
  logic                accept;
  logic                consume;
  logic                in_ready;

  logic [PHRASE_W-1:0] ext_phrase;
  idx_t                ext_index;
  mode_e               ext_mode;
  logic                ext_sign;
  logic [PIX_W-1:0]    ext_pix;

  assign in_mode  = decode_mode(bus.in_sixteen, bus.in_twentyfour);
  assign start_m  = bus.in_start & start_mask(in_mode);
  assign in_ready = !reset && !flush && ((state_q == ST_EMPTY) || (bus.out_ready && last_q));
  assign accept   = bus.in_valid && in_ready;
  assign consume  = (state_q == ST_HOLD) && bus.out_ready;

  // One extender serves both the first pixel of a new phrase and the next
  // pixel of the held one, so out_data can be registered.
  assign ext_phrase = accept ? bus.in_data      : phrase_q;
  assign ext_index  = accept ? start_m          : index_q + 3'd1;
  assign ext_mode   = accept ? in_mode          : mode_q;
  assign ext_sign   = accept ? bus.in_sign_ext  : sign_q;

  pix_extend u_extend (
    .phrase_i   (ext_phrase),
    .index_i    (ext_index),
    .mode_i     (ext_mode),
    .sign_ext_i (ext_sign),
    .pix_o      (ext_pix)
  );

  always_comb begin
    state_d  = state_q;
    phrase_d = phrase_q;
    mode_d   = mode_q;
    sign_d   = sign_q;
    index_d  = index_q;
    data_d   = data_q;
    last_d   = last_q;
    if (flush) begin
      state_d = ST_EMPTY;
      index_d = '0;
      data_d  = '0;
      last_d  = 1'b0;
    end else if (accept) begin
      state_d  = ST_HOLD;
      phrase_d = bus.in_data;
      mode_d   = in_mode;
      sign_d   = bus.in_sign_ext;
      index_d  = start_m;
      data_d   = ext_pix;
      last_d   = (start_m == start_mask(in_mode));
    end else if (consume) begin
      if (last_q) begin
        state_d = ST_EMPTY;
        index_d = '0;
        last_d  = 1'b0;
      end else begin
        index_d = ext_index;
        data_d  = ext_pix;
        last_d  = (ext_index == start_mask(mode_q));
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      phrase_q <= '0;
      mode_q   <= MODE_8;
      sign_q   <= 1'b0;
      index_q  <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phrase_q <= phrase_d;
      mode_q   <= mode_d;
      sign_q   <= sign_d;
      index_q  <= index_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

endmodule
